mpu_dispatcher_param: RTL and testbench

// - Parametrised operand dispatcher between the matrix register file and a DIM x DIM FMA cluster.
// - For C = A(DIM x K) * B(K x DIM), each wave k (K-1 down to 0) delivers A[l][k] to row lane l and B[k][l] to column lane l.
// - Lane l of a wave is issued on cycle l of that wave; lanes are issued in ascending order.
// - Inner dimension K is set at run time, up to KMAX. The dispatcher stalls between waves until the cluster reports idle.

---
 rtl/mpu_dispatcher_param_pkg.sv | 16 +
 rtl/mpu_disp_lane_demux.sv | 48 ++++
 rtl/mpu_dispatcher_param.sv | 162 ++++++++++++++++
 tb/tb_mpu_dispatcher_param.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_dispatcher_param_pkg.sv
// Shared types and defaults for the MPU operand dispatcher.
// Dispatcher FSM encodings, element type and default cluster geometry.
package mpu_dispatcher_param_pkg;

   localparam int DEF_DIM  = 3;
   localparam int DEF_KMAX = 8;

   typedef logic [31:0] float_sp;
   typedef logic [1:0]  disp_p_state_e;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/mpu_disp_lane_demux.sv
// Registers one element onto a single lane of a DIM-wide bus.
// Emits a one-hot strobe; every slice other than the selected lane is zero.
module mpu_disp_lane_demux
   import mpu_dispatcher_param_pkg::*;
#(
   parameter int DIM = DEF_DIM,
   parameter int DW  = 32,
   parameter int LB  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic [LB-1:0]     lane_i,
   input  logic [DW-1:0]     elem_i,
   output logic [DIM-1:0]    req_o,
   output logic [DIM*DW-1:0] data_o
);

   logic [DIM-1:0]    req_q;
   logic [DIM-1:0]    req_d;
   logic [DIM*DW-1:0] data_q;
   logic [DIM*DW-1:0] data_d;

   always_comb begin
      req_d  = '0;
      data_d = '0;
      for (int l = 0; l < DIM; l++) begin
         if (en_i && lane_i == LB'(l)) begin
            req_d[l]           = 1'b1;
            data_d[l*DW +: DW] = elem_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q  <= '0;
         data_q <= '0;
      end else begin
         req_q  <= req_d;
         data_q <= data_d;
      end
   end

   assign req_o  = req_q;
   assign data_o = data_q;

endmodule

// File: rtl/mpu_dispatcher_param.sv
// Operand dispatcher: streams A columns / B rows into a DIM x DIM FMA cluster.
// Define MPU_DISP_PERF_EN to add stall/wave performance counters.
module mpu_dispatcher_param
   import mpu_dispatcher_param_pkg::*;
#(
   parameter int  DIM  = DEF_DIM,
   parameter int  KMAX = DEF_KMAX,
   parameter int  DW   = 32,
   localparam int LB   = $clog2(DIM),
   localparam int KB   = $clog2(KMAX)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [KB:0]        k_len_i,
   output logic               ack_o,
   output logic               done_o,
   input  logic [DIM*DIM-1:0] busy_i,
   output logic [LB-1:0]      a_row_o,
   output logic [KB-1:0]      a_col_o,
   output logic [KB-1:0]      b_row_o,
   output logic [LB-1:0]      b_col_o,
   input  logic [DW-1:0]      a_elem_i,
   input  logic [DW-1:0]      b_elem_i,
`ifdef MPU_DISP_PERF_EN
   output logic [31:0]        stall_cnt_o,
   output logic [31:0]        wave_cnt_o,
`endif
   output logic [DIM-1:0]     a_req_o,
   output logic [DIM*DW-1:0]  a_data_o,
   output logic [DIM-1:0]     b_req_o,
   output logic [DIM*DW-1:0]  b_data_o
);

   disp_p_state_e state_q;
   disp_p_state_e state_d;
   logic [LB-1:0] lane_q;
   logic [LB-1:0] lane_d;
   logic [KB-1:0] k_q;
   logic [KB-1:0] k_d;
   logic          done_q;
   logic          done_d;
   logic          cfree;
   logic          last_lane;
   logic          issue_en;
   logic [KB:0]   k_eff;

   always_comb begin
      cfree     = ~|busy_i;
      last_lane = (lane_q == LB'(DIM-1));
      k_eff     = (k_len_i > (KB+1)'(KMAX)) ? (KB+1)'(KMAX) : k_len_i;
      state_d   = state_q;
      lane_d    = lane_q;
      k_d       = k_q;
      case (state_q)
         S_IDLE: begin
            if (start_i && cfree && k_eff != '0) begin
               state_d = S_ISSUE;
               k_d     = KB'(k_eff - 1'b1);
               lane_d  = '0;
            end
         end
         S_ISSUE: begin
            if (!last_lane) begin
               lane_d = lane_q + 1'b1;
            end else if (k_q == '0) begin
               state_d = S_DONE;
            end else begin
               k_d     = k_q - 1'b1;
               lane_d  = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cfree) state_d = S_ISSUE;
         end
         default: state_d = S_IDLE;
      endcase
      // abort wins over every other transition outside IDLE
      if (abort_i && state_q != S_IDLE) begin
         state_d = S_IDLE;
         lane_d  = '0;
      end
      issue_en = (state_q == S_ISSUE) && !abort_i;
      done_d   = (state_q == S_DONE) && !abort_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         lane_q  <= '0;
         k_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         k_q     <= k_d;
         done_q  <= done_d;
      end
   end

   assign ack_o   = (state_q != S_IDLE);
   assign done_o  = done_q;
   assign a_row_o = (state_q == S_ISSUE) ? lane_q : '0;
   assign a_col_o = (state_q == S_ISSUE) ? k_q : '0;
   assign b_row_o = (state_q == S_ISSUE) ? k_q : '0;
   assign b_col_o = (state_q == S_ISSUE) ? lane_q : '0;

   mpu_disp_lane_demux #(.DIM(DIM), .DW(DW), .LB(LB)) u_a_demux (
      .clk    (clk),
      .rst    (rst),
      .en_i   (issue_en),
      .lane_i (lane_q),
      .elem_i (a_elem_i),
      .req_o  (a_req_o),
      .data_o (a_data_o)
   );

   mpu_disp_lane_demux #(.DIM(DIM), .DW(DW), .LB(LB)) u_b_demux (
      .clk    (clk),
      .rst    (rst),
      .en_i   (issue_en),
      .lane_i (lane_q),
      .elem_i (b_elem_i),
      .req_o  (b_req_o),
      .data_o (b_data_o)
   );

`ifdef MPU_DISP_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] stall_d;
   logic [31:0] wave_q;
   logic [31:0] wave_d;

   always_comb begin
      stall_d = stall_q;
      wave_d  = wave_q;
      if (state_q == S_IDLE && state_d == S_ISSUE) begin
         stall_d = '0;
         wave_d  = '0;
      end else begin
         if (state_q == S_WAIT && !cfree && !(&stall_q)) stall_d = stall_q + 1'b1;
         if (issue_en && last_lane && !(&wave_q))        wave_d  = wave_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         wave_q  <= '0;
      end else begin
         stall_q <= stall_d;
         wave_q  <= wave_d;
      end
   end

   assign stall_cnt_o = stall_q;
   assign wave_cnt_o  = wave_q;
`endif

endmodule

// File: tb/tb_mpu_dispatcher_param.sv
// Self-checking bench for mpu_dispatcher_param (DIM=3, KMAX=8, DW=32).
// Scoreboard of expected lane strobes plus directed timing checks.
module tb_mpu_dispatcher_param;

   localparam int DIM  = 3;
   localparam int KMAX = 8;
   localparam int DW   = 32;
   localparam int LB   = $clog2(DIM);
   localparam int KB   = $clog2(KMAX);

   typedef struct {
      int          lane;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start_i = 1'b0;
   logic               abort_i = 1'b0;
   logic [KB:0]        k_len_i = '0;
   logic               ack_o;
   logic               done_o;
   logic [DIM*DIM-1:0] busy_i = '0;
   logic [LB-1:0]      a_row_o;
   logic [KB-1:0]      a_col_o;
   logic [KB-1:0]      b_row_o;
   logic [LB-1:0]      b_col_o;
   logic [DW-1:0]      a_elem_i;
   logic [DW-1:0]      b_elem_i;
   logic [DIM-1:0]     a_req_o;
   logic [DIM*DW-1:0]  a_data_o;
   logic [DIM-1:0]     b_req_o;
   logic [DIM*DW-1:0]  b_data_o;
`ifdef MPU_DISP_PERF_EN
   logic [31:0]        stall_cnt_o;
   logic [31:0]        wave_cnt_o;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   done_cyc = -1;
   exp_t exp_q[$];
   int   strobe_cyc_q[$];

   mpu_dispatcher_param #(.DIM(DIM), .KMAX(KMAX), .DW(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .k_len_i     (k_len_i),
      .ack_o       (ack_o),
      .done_o      (done_o),
      .busy_i      (busy_i),
      .a_row_o     (a_row_o),
      .a_col_o     (a_col_o),
      .b_row_o     (b_row_o),
      .b_col_o     (b_col_o),
      .a_elem_i    (a_elem_i),
      .b_elem_i    (b_elem_i),
`ifdef MPU_DISP_PERF_EN
      .stall_cnt_o (stall_cnt_o),
      .wave_cnt_o  (wave_cnt_o),
`endif
      .a_req_o     (a_req_o),
      .a_data_o    (a_data_o),
      .b_req_o     (b_req_o),
      .b_data_o    (b_data_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] a_val(input int r, input int c);
      return 32'hA000_0000 + 32'(r * 16 + c);
   endfunction

   function automatic logic [31:0] b_val(input int r, input int c);
      return 32'hB000_0000 + 32'(r * 16 + c);
   endfunction

   // register-file model: combinational read of the driven addresses
   assign a_elem_i = a_val(int'(a_row_o), int'(a_col_o));
   assign b_elem_i = b_val(int'(b_row_o), int'(b_col_o));

   function automatic logic [DIM*DW-1:0] bus(input int lane, input logic [31:0] v);
      logic [DIM*DW-1:0] r;
      r = '0;
      r[lane*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [DIM-1:0] onehot(input int lane);
      logic [DIM-1:0] r;
      r = '0;
      r[lane] = 1'b1;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_one(input int l, input int k);
      exp_q.push_back('{l, a_val(l, k), b_val(k, l)});
   endtask

   task automatic push_product(input int kk);
      for (int k = kk - 1; k >= 0; k--)
         for (int l = 0; l < DIM; l++)
            push_one(l, k);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (a_req_o !== '0 || b_req_o !== '0) begin
         strobe_cyc_q.push_back(cyc);
         chk("strobe_expected", 128'(exp_q.size() != 0), 128'(1));
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("a_req", 128'(a_req_o), 128'(onehot(e.lane)));
            chk("b_req", 128'(b_req_o), 128'(onehot(e.lane)));
            chk("a_data", 128'(a_data_o), 128'(bus(e.lane, e.a)));
            chk("b_data", 128'(b_data_o), 128'(bus(e.lane, e.b)));
         end
      end else begin
         chk("idle_data", 128'({a_data_o, b_data_o}), 128'(0));
      end
      if (done_o === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic launch(input int klen);
      @(negedge clk);
      strobe_cyc_q.delete();
      k_len_i = (KB+1)'(klen);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      chk("ack_high", 128'(ack_o), 128'(1));
   endtask

   task automatic wait_done(input string tag);
      int d0;
      int n;
      d0 = done_cnt;
      n  = 0;
      while (done_cnt == d0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 128'(done_cnt - d0), 128'(1));
      repeat (3) @(negedge clk);
      chk({tag, "_single"}, 128'(done_cnt - d0), 128'(1));
   endtask

   task automatic check_run(input string tag, input int n_str, input int span);
      int first;
      int last;
      first = (strobe_cyc_q.size() > 0) ? strobe_cyc_q[0] : -100;
      last  = (strobe_cyc_q.size() > 0) ? strobe_cyc_q[strobe_cyc_q.size()-1] : -100;
      chk({tag, "_count"}, 128'(strobe_cyc_q.size()), 128'(n_str));
      chk({tag, "_span"}, 128'(last - first), 128'(span));
      chk({tag, "_done_lat"}, 128'(done_cyc - last), 128'(1));
      chk({tag, "_sb_empty"}, 128'(exp_q.size()), 128'(0));
      chk({tag, "_ack_low"}, 128'(ack_o), 128'(0));
   endtask

   initial begin
      int d0;
      repeat (2) @(negedge clk);
      chk("rst_ack", 128'(ack_o), 128'(0));
      chk("rst_done", 128'(done_o), 128'(0));
      chk("rst_req", 128'({a_req_o, b_req_o}), 128'(0));
      chk("rst_addr", 128'({a_row_o, a_col_o, b_row_o, b_col_o}), 128'(0));
      rst = 1'b0;

      push_product(3);
      launch(3);
      wait_done("k3_done");
      check_run("k3", 9, 10);
`ifdef MPU_DISP_PERF_EN
      chk("k3_stall", 128'(stall_cnt_o), 128'(0));
      chk("k3_wave", 128'(wave_cnt_o), 128'(3));
`endif

      push_product(3);
      launch(3);
      repeat (3) @(negedge clk);
      chk("stall_pre_last", 128'(a_req_o), 128'(3'b100));
      busy_i = 9'h010;
      for (int i = 4; i <= 9; i++) begin
         @(negedge clk);
         chk("stall_no_strobe", 128'({a_req_o, b_req_o}), 128'(0));
         if (i == 8) busy_i = '0;
      end
      @(negedge clk);
      chk("stall_resume", 128'(a_req_o), 128'(3'b001));
      wait_done("stall_done");
      check_run("stall", 9, 15);
`ifdef MPU_DISP_PERF_EN
      chk("stall_cnt", 128'(stall_cnt_o), 128'(5));
      chk("wave_cnt", 128'(wave_cnt_o), 128'(3));
`endif

      push_product(1);
      launch(1);
      wait_done("k1_done");
      check_run("k1", 3, 2);

      push_product(KMAX);
      launch(15);
      wait_done("clamp_done");
      check_run("clamp", 3 * KMAX, 3 * KMAX - 1 + (KMAX - 1));

      for (int l = 0; l < DIM; l++) push_one(l, 2);
      push_one(0, 1);
      d0 = done_cnt;
      launch(3);
      repeat (5) @(negedge clk);
      chk("abort_addr", 128'({a_row_o, a_col_o, b_row_o, b_col_o}),
          128'({2'd1, 3'd1, 3'd1, 2'd1}));
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      chk("abort_req", 128'({a_req_o, b_req_o}), 128'(0));
      chk("abort_ack", 128'(ack_o), 128'(0));
      repeat (4) @(negedge clk);
      chk("abort_no_done", 128'(done_cnt - d0), 128'(0));
      chk("abort_count", 128'(strobe_cyc_q.size()), 128'(4));
      chk("abort_sb_empty", 128'(exp_q.size()), 128'(0));

      k_len_i = '0;
      start_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("kzero_ack", 128'(ack_o), 128'(0));
      end
      start_i = 1'b0;

      push_one(0, 2);
      launch(3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_ack", 128'({ack_o, done_o}), 128'(0));
      chk("mrst_req", 128'({a_req_o, b_req_o}), 128'(0));
      chk("mrst_data", 128'({a_data_o, b_data_o}), 128'(0));
      chk("mrst_addr", 128'({a_row_o, a_col_o, b_row_o, b_col_o}), 128'(0));
      chk("mrst_sb_empty", 128'(exp_q.size()), 128'(0));
`ifdef MPU_DISP_PERF_EN
      chk("mrst_perf", 128'({stall_cnt_o, wave_cnt_o}), 128'(0));
`endif

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
